ctrl_pipe_carrier: RTL and testbench
====================================

// Module: ctrl_pipe_carrier
// PURPOSE
//  Consumer side of the 19-bit control word produced in ID. Unpacks the word into named fields
//  and carries them through the ID/EX, EX/MEM and MEM/WB registers, each stage holding only the
//  bits it still needs. Inserts bubbles on hazard stall or branch/jump flush, freezes on debug halt,
//  and reports pipeline occupancy plus a retired-instruction count to the debug unit.
// PARAMETERS
//  CTRL_W    19  control word width; field map below is fixed to 19
//  RETIRE_W  32  width of the retired-instruction counter
// PORTS
//  i_clk               in   1        system clock, rising edge
//  i_reset             in   1        asynchronous, active-high reset
//  i_halt              in   1        debug freeze; every stage holds
//  i_stall             in   1        load-use hazard; ID/EX loads a bubble
//  i_flush             in   1        taken jump/branch; ID/EX loads a bubble
//  i_valid             in   1        ID stage holds a real instruction
//  i_ctrl_regs         in   CTRL_W   control word from main control
//  o_ex_reg_dst        out  2        ID/EX bits 15:14
//  o_ex_alu_src_a      out  1        ID/EX bit 13
//  o_ex_alu_src_b      out  2        ID/EX bits 12:11
//  o_ex_alu_op         out  3        ID/EX bits 10:8
//  o_ex_mem_read       out  1        ID/EX mem_rd_src != 0, for hazard unit
//  o_mem_rd_src        out  3        EX/MEM bits 7:5
//  o_mem_wr_src        out  2        EX/MEM bits 4:3
//  o_mem_write         out  1        EX/MEM bit 2
//  o_wb_enable         out  1        MEM/WB bit 1
//  o_wb_mem_to_reg     out  1        MEM/WB bit 0
//  o_pipe_empty        out  1        no valid instruction in any carried stage
//  o_retired_count     out  RETIRE_W instructions leaving MEM/WB
// BEHAVIOUR
//  - Field map: b18 next_pc_src, b17:16 jmp_ctrl, b15:14 reg_dst, b13 alu_src_a, b12:11 alu_src_b,
//    b10:8 alu_op, b7:5 mem_rd_src, b4:3 mem_wr_src, b2 mem_write, b1 wb, b0 mem_to_reg.
//  - Bubble is the all-zero word with valid=0. Zero encodes SEQ, NOT_JMP, MEM_WRITE_DISABLE,
//    WB_DISABLE and MEM_RD_SRC_NOTHING.
//  - Storage: ID/EX holds bits 15:0 plus valid. EX/MEM holds bits 7:0 plus valid.
//    MEM/WB holds bits 1:0 plus valid. Bits 18:16 are consumed in ID and are not stored.
//  - Reset: all stage registers clear to bubble; every output is 0; o_pipe_empty=1; counter=0.
//  - Per cycle, in priority order:
//    1. i_halt=1: all registers and the counter hold. Stall and flush are ignored.
//    2. Otherwise EX/MEM<=ID/EX[7:0] and MEM/WB<=EX/MEM[1:0], each with its valid bit.
//       If i_stall or i_flush (or both), ID/EX<=bubble; else ID/EX<={i_ctrl_regs[15:0], i_valid}.
//  - Every output is a registered field, giving 1-cycle latency per stage. An ID word appears on
//    EX outputs +1, MEM outputs +2, WB outputs +3 cycles.
//  - A stage whose valid bit is 0 forces its outputs to 0 regardless of stored bits, so a write is
//    never issued for an invalid slot.
//  - o_retired_count increments when MEM/WB is valid and i_halt=0. It wraps modulo 2^RETIRE_W.
//  - o_pipe_empty is the combinational NOR of the three valid bits.
//  - Reset asserted mid-operation clears all state immediately (async). The first capture happens
//    on the first edge after deassertion.
// STRUCTURE
//  - Shared package/header: field bit positions, widths, the bubble constant and NOTHING/disable
//    encodings, all taken from the main-control header.
//  - One sub-module, ctrl_stage_reg: a parameterised-width register with valid bit, hold (halt)
//    and load-bubble controls, instantiated three times. The counter and output gating sit in the top.
// TESTING
//  - Reset: i_reset=1 mid-stream -> all outputs 0 and o_pipe_empty=1 in the same cycle;
//    counter reads 0.
//  - LW word (wb=1, mem_to_reg=1, mem_rd_src=WORD, alu_src_b=SIG_INM), i_valid=1 ->
//    o_ex_alu_src_b at +1, o_ex_mem_read=1 at +1, o_mem_rd_src=WORD at +2,
//    o_wb_enable=1 and o_wb_mem_to_reg=1 at +3, counter 0->1 at +4.
//  - SW followed by i_stall=1 for 1 cycle -> o_mem_write=1 exactly once; bubble shows all-zero
//    EX outputs for 1 cycle; counter advances by 1 only.
//  - i_flush=1 together with i_stall=1 on an ADDI word -> ADDI never appears;
//    o_wb_enable stays 0 at +3.
//  - i_halt=1 for 5 cycles with 3 valid stages -> outputs and counter frozen; resume ->
//    sequence continues unchanged.
//  - RETIRE_W=4: retire 17 instructions -> o_retired_count=1 (wrap). After drain,
//    o_pipe_empty=1 exactly 3 cycles after the last valid ID word.

Source files
------------

// File: rtl/ctrl_pipe_carrier_pkg.sv
// Control-word field layout and encodings shared by the ID/EX, EX/MEM and MEM/WB carriers.
// Field positions and zero encodings mirror the main-control header.
package ctrl_pipe_carrier_pkg;

  localparam int CTRL_WORD_W = 19;

  // Full word as produced by main control in ID
  typedef struct packed {
    logic       next_pc_src;  // b18
    logic [1:0] jmp_ctrl;     // b17:16
    logic [1:0] reg_dst;      // b15:14
    logic       alu_src_a;    // b13
    logic [1:0] alu_src_b;    // b12:11
    logic [2:0] alu_op;       // b10:8
    logic [2:0] mem_rd_src;   // b7:5
    logic [1:0] mem_wr_src;   // b4:3
    logic       mem_write;    // b2
    logic       wb;           // b1
    logic       mem_to_reg;   // b0
  } ctrl_word_t;

  // Stage payloads keep the low bits of the word in their original order
  typedef struct packed {
    logic [1:0] reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [2:0] mem_rd_src;
    logic [1:0] mem_wr_src;
    logic       mem_write;
    logic       wb;
    logic       mem_to_reg;
  } idex_t;

  typedef struct packed {
    logic [2:0] mem_rd_src;
    logic [1:0] mem_wr_src;
    logic       mem_write;
    logic       wb;
    logic       mem_to_reg;
  } exmem_t;

  typedef struct packed {
    logic wb;
    logic mem_to_reg;
  } memwb_t;

  localparam int IDEX_W  = $bits(idex_t);
  localparam int EXMEM_W = $bits(exmem_t);
  localparam int MEMWB_W = $bits(memwb_t);

  localparam logic       NEXT_PC_SEQ          = 1'b0;
  localparam logic [1:0] NOT_JMP              = 2'd0;
  localparam logic       MEM_WRITE_DISABLE    = 1'b0;
  localparam logic       WB_DISABLE           = 1'b0;
  localparam logic [2:0] MEM_RD_SRC_NOTHING   = 3'd0;
  localparam logic [2:0] MEM_RD_SRC_BYTE      = 3'd1;
  localparam logic [2:0] MEM_RD_SRC_HALF      = 3'd2;
  localparam logic [2:0] MEM_RD_SRC_WORD      = 3'd3;
  localparam logic [2:0] MEM_RD_SRC_BYTE_U    = 3'd4;
  localparam logic [2:0] MEM_RD_SRC_HALF_U    = 3'd5;
  localparam logic [1:0] ALU_SRC_B_REG        = 2'd0;
  localparam logic [1:0] ALU_SRC_B_SIG_INM    = 2'd1;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

  function automatic logic reads_memory(input logic [2:0] mem_rd_src);
    return mem_rd_src != MEM_RD_SRC_NOTHING;
  endfunction

endpackage

// File: rtl/ctrl_pipe_carrier_stage_reg.sv
// Pipeline register with valid bit: holds on halt, loads the all-zero bubble on request.
// Latency 1 cycle; hold has priority over bubble, so a frozen stage never loses its contents.
// No backpressure of its own; the caller decides hold/bubble each cycle.
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         load_bubble,
  input  logic [W-1:0] d_dat,
  input  logic         d_vld,
  output logic [W-1:0] q_dat,
  output logic         q_vld
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_dat <= '0;
      q_vld <= 1'b0;
    end else if (!hold) begin
      if (load_bubble) begin
        q_dat <= '0;
        q_vld <= 1'b0;
      end else begin
        q_dat <= d_dat;
        q_vld <= d_vld;
      end
    end
  end

endmodule

// File: rtl/ctrl_pipe_carrier.sv
// Carries the ID control word through ID/EX, EX/MEM, MEM/WB, trimming bits per stage.
// Latency: EX outputs +1, MEM +2, WB +3 cycles; stall/flush inject an ID/EX bubble.
// Halt freezes every stage and the retire counter; no other backpressure.
module ctrl_pipe_carrier
  import ctrl_pipe_carrier_pkg::*;
#(
  parameter int CTRL_W   = 19,
  parameter int RETIRE_W = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_halt,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_valid,
  input  logic [CTRL_W-1:0]   i_ctrl_regs,
  output logic [1:0]          o_ex_reg_dst,
  output logic                o_ex_alu_src_a,
  output logic [1:0]          o_ex_alu_src_b,
  output logic [2:0]          o_ex_alu_op,
  output logic                o_ex_mem_read,
  output logic [2:0]          o_mem_rd_src,
  output logic [1:0]          o_mem_wr_src,
  output logic                o_mem_write,
  output logic                o_wb_enable,
  output logic                o_wb_mem_to_reg,
  output logic                o_pipe_empty,
  output logic [RETIRE_W-1:0] o_retired_count
);

  ctrl_word_t id_word;
  assign id_word = ctrl_word_t'(i_ctrl_regs);

  // next_pc_src and jmp_ctrl are resolved in ID and never travel further
  logic unused_id_bits;
  assign unused_id_bits = ^{id_word.next_pc_src, id_word.jmp_ctrl};

  idex_t                idex_d;
  logic [IDEX_W-1:0]    idex_q;
  logic                 idex_vld;
  idex_t                idex;
  exmem_t               exmem_d;
  logic [EXMEM_W-1:0]   exmem_q;
  logic                 exmem_vld;
  exmem_t               exmem;
  memwb_t               memwb_d;
  logic [MEMWB_W-1:0]   memwb_q;
  logic                 memwb_vld;
  memwb_t               memwb;
  logic                 id_bubble;

  assign id_bubble = i_stall | i_flush;

  always_comb begin
    idex_d            = '0;
    idex_d.reg_dst    = id_word.reg_dst;
    idex_d.alu_src_a  = id_word.alu_src_a;
    idex_d.alu_src_b  = id_word.alu_src_b;
    idex_d.alu_op     = id_word.alu_op;
    idex_d.mem_rd_src = id_word.mem_rd_src;
    idex_d.mem_wr_src = id_word.mem_wr_src;
    idex_d.mem_write  = id_word.mem_write;
    idex_d.wb         = id_word.wb;
    idex_d.mem_to_reg = id_word.mem_to_reg;
  end

  ctrl_stage_reg #(.W(IDEX_W)) u_idex (
    .clk         (i_clk),
    .rst         (i_reset),
    .hold        (i_halt),
    .load_bubble (id_bubble),
    .d_dat       (idex_d),
    .d_vld       (i_valid),
    .q_dat       (idex_q),
    .q_vld       (idex_vld)
  );
  assign idex = idex_t'(idex_q);

  always_comb begin
    exmem_d            = '0;
    exmem_d.mem_rd_src = idex.mem_rd_src;
    exmem_d.mem_wr_src = idex.mem_wr_src;
    exmem_d.mem_write  = idex.mem_write;
    exmem_d.wb         = idex.wb;
    exmem_d.mem_to_reg = idex.mem_to_reg;
  end

  ctrl_stage_reg #(.W(EXMEM_W)) u_exmem (
    .clk         (i_clk),
    .rst         (i_reset),
    .hold        (i_halt),
    .load_bubble (1'b0),
    .d_dat       (exmem_d),
    .d_vld       (idex_vld),
    .q_dat       (exmem_q),
    .q_vld       (exmem_vld)
  );
  assign exmem = exmem_t'(exmem_q);

  always_comb begin
    memwb_d            = '0;
    memwb_d.wb         = exmem.wb;
    memwb_d.mem_to_reg = exmem.mem_to_reg;
  end

  ctrl_stage_reg #(.W(MEMWB_W)) u_memwb (
    .clk         (i_clk),
    .rst         (i_reset),
    .hold        (i_halt),
    .load_bubble (1'b0),
    .d_dat       (memwb_d),
    .d_vld       (exmem_vld),
    .q_dat       (memwb_q),
    .q_vld       (memwb_vld)
  );
  assign memwb = memwb_t'(memwb_q);

  // Invalid slots present as zero so no stale write or load escapes a bubble
  always_comb begin
    o_ex_reg_dst    = '0;
    o_ex_alu_src_a  = 1'b0;
    o_ex_alu_src_b  = '0;
    o_ex_alu_op     = '0;
    o_ex_mem_read   = 1'b0;
    o_mem_rd_src    = MEM_RD_SRC_NOTHING;
    o_mem_wr_src    = '0;
    o_mem_write     = MEM_WRITE_DISABLE;
    o_wb_enable     = WB_DISABLE;
    o_wb_mem_to_reg = 1'b0;
    if (idex_vld) begin
      o_ex_reg_dst   = idex.reg_dst;
      o_ex_alu_src_a = idex.alu_src_a;
      o_ex_alu_src_b = idex.alu_src_b;
      o_ex_alu_op    = idex.alu_op;
      o_ex_mem_read  = reads_memory(idex.mem_rd_src);
    end
    if (exmem_vld) begin
      o_mem_rd_src = exmem.mem_rd_src;
      o_mem_wr_src = exmem.mem_wr_src;
      o_mem_write  = exmem.mem_write;
    end
    if (memwb_vld) begin
      o_wb_enable     = memwb.wb;
      o_wb_mem_to_reg = memwb.mem_to_reg;
    end
  end

  assign o_pipe_empty = ~(idex_vld | exmem_vld | memwb_vld);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_retired_count <= '0;
    end else if (!i_halt && memwb_vld) begin
      o_retired_count <= o_retired_count + RETIRE_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_carrier.sv
// Directed bench for ctrl_pipe_carrier with a 4-bit retire counter to reach wrap quickly.
module tb_ctrl_pipe_carrier;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt, stall, flush, valid;
  logic [18:0] ctrl;
  logic [1:0]  ex_reg_dst;
  logic        ex_alu_src_a;
  logic [1:0]  ex_alu_src_b;
  logic [2:0]  ex_alu_op;
  logic        ex_mem_read;
  logic [2:0]  mem_rd_src;
  logic [1:0]  mem_wr_src;
  logic        mem_write;
  logic        wb_enable;
  logic        wb_mem_to_reg;
  logic        pipe_empty;
  logic [3:0]  retired;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_pipe_carrier #(.CTRL_W(19), .RETIRE_W(4)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_halt          (halt),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_valid         (valid),
    .i_ctrl_regs     (ctrl),
    .o_ex_reg_dst    (ex_reg_dst),
    .o_ex_alu_src_a  (ex_alu_src_a),
    .o_ex_alu_src_b  (ex_alu_src_b),
    .o_ex_alu_op     (ex_alu_op),
    .o_ex_mem_read   (ex_mem_read),
    .o_mem_rd_src    (mem_rd_src),
    .o_mem_wr_src    (mem_wr_src),
    .o_mem_write     (mem_write),
    .o_wb_enable     (wb_enable),
    .o_wb_mem_to_reg (wb_mem_to_reg),
    .o_pipe_empty    (pipe_empty),
    .o_retired_count (retired)
  );

  // Upper bits set to 3'b110 so anything leaking from b18:16 would be visible as garbage
  function automatic logic [18:0] mk(input logic [1:0] rdst, input logic sa, input logic [1:0] sb,
                                     input logic [2:0] op, input logic [2:0] mrs,
                                     input logic [1:0] mws, input logic mw, input logic wb,
                                     input logic m2r);
    return {3'b110, rdst, sa, sb, op, mrs, mws, mw, wb, m2r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [18:0] w, input logic v, input logic s, input logic f,
                       input logic h);
    ctrl = w; valid = v; stall = s; flush = f; halt = h;
  endtask

  task automatic do_reset();
    drive(19'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] lw;
    lw = mk(2'd0, 1'b0, 2'd1, 3'd0, 3'd3, 2'd0, 1'b0, 1'b1, 1'b1);
    do_reset();
    checks++;
    if ({ex_reg_dst, ex_alu_src_a, ex_alu_src_b, ex_alu_op, ex_mem_read, mem_rd_src, mem_wr_src,
         mem_write, wb_enable, wb_mem_to_reg} !== 18'd0 || pipe_empty !== 1'b1 || retired !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: outs=%h empty=%b cnt=%0d, want outs=0 empty=1 cnt=0",
               {ex_reg_dst, ex_alu_op, mem_rd_src, mem_write, wb_enable}, pipe_empty, retired);
    end
    drive(lw, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ex_alu_src_b, ex_mem_read, mem_rd_src, wb_enable} !== 7'd0 || pipe_empty !== 1'b1
        || retired !== 4'd0) begin
      failures++;
      $display("FAIL async_reset: srcb=%0d mrd=%b rdsrc=%0d empty=%b cnt=%0d, want all 0 and empty=1",
               ex_alu_src_b, ex_mem_read, mem_rd_src, pipe_empty, retired);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ex_alu_src_b !== 2'd1 || ex_mem_read !== 1'b1) begin
      failures++;
      $display("FAIL first_capture: srcb=%0d mrd=%b, want 1 1", ex_alu_src_b, ex_mem_read);
    end
  endtask

  task automatic test_lw();
    do_reset();
    drive(mk(2'd0, 1'b0, 2'd1, 3'd0, 3'd3, 2'd0, 1'b0, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(19'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ex_alu_src_b !== 2'd1 || ex_mem_read !== 1'b1 || mem_rd_src !== 3'd0) begin
      failures++;
      $display("FAIL lw_ex: srcb=%0d mrd=%b rdsrc=%0d, want 1 1 0", ex_alu_src_b, ex_mem_read, mem_rd_src);
    end
    tick();
    checks++;
    if (mem_rd_src !== 3'd3 || ex_mem_read !== 1'b0 || wb_enable !== 1'b0) begin
      failures++;
      $display("FAIL lw_mem: rdsrc=%0d mrd=%b wb=%b, want 3 0 0", mem_rd_src, ex_mem_read, wb_enable);
    end
    tick();
    checks++;
    if (wb_enable !== 1'b1 || wb_mem_to_reg !== 1'b1 || retired !== 4'd0) begin
      failures++;
      $display("FAIL lw_wb: wb=%b m2r=%b cnt=%0d, want 1 1 0", wb_enable, wb_mem_to_reg, retired);
    end
    tick();
    checks++;
    if (retired !== 4'd1 || wb_enable !== 1'b0 || pipe_empty !== 1'b1) begin
      failures++;
      $display("FAIL lw_retire: cnt=%0d wb=%b empty=%b, want 1 0 1", retired, wb_enable, pipe_empty);
    end
  endtask

  task automatic test_stall();
    int writes;
    do_reset();
    drive(mk(2'd0, 1'b0, 2'd1, 3'd0, 3'd0, 2'd3, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(mk(2'd1, 1'b0, 2'd0, 3'd2, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(19'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({ex_reg_dst, ex_alu_src_a, ex_alu_src_b, ex_alu_op, ex_mem_read} !== 9'd0
        || mem_wr_src !== 2'd3) begin
      failures++;
      $display("FAIL stall_bubble: ex=%h wrsrc=%0d, want ex=0 wrsrc=3",
               {ex_reg_dst, ex_alu_src_a, ex_alu_src_b, ex_alu_op, ex_mem_read}, mem_wr_src);
    end
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_write === 1'b1) writes++;
      tick();
    end
    checks++;
    if (writes !== 1) begin
      failures++;
      $display("FAIL stall_mem_write_once: writes=%0d, want 1", writes);
    end
    checks++;
    if (retired !== 4'd1) begin
      failures++;
      $display("FAIL stall_retire: cnt=%0d, want 1", retired);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(mk(2'd0, 1'b0, 2'd1, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(19'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ex_alu_src_b !== 2'd0 || pipe_empty !== 1'b1) begin
      failures++;
      $display("FAIL flush_ex: srcb=%0d empty=%b, want 0 1", ex_alu_src_b, pipe_empty);
    end
    tick();
    tick();
    checks++;
    if (wb_enable !== 1'b0 || retired !== 4'd0) begin
      failures++;
      $display("FAIL flush_wb: wb=%b cnt=%0d, want 0 0", wb_enable, retired);
    end
  endtask

  task automatic test_halt();
    do_reset();
    drive(mk(2'd1, 1'b0, 2'd0, 3'd1, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(mk(2'd0, 1'b0, 2'd1, 3'd0, 3'd3, 2'd0, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(mk(2'd2, 1'b1, 2'd0, 3'd5, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(mk(2'd3, 1'b1, 2'd2, 3'd7, 3'd1, 2'd1, 1'b1, 1'b1, 1'b1), 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ex_alu_op !== 3'd5 || ex_reg_dst !== 2'd2 || mem_rd_src !== 3'd3 || wb_enable !== 1'b1
          || wb_mem_to_reg !== 1'b0 || retired !== 4'd0 || pipe_empty !== 1'b0) begin
        failures++;
        $display("FAIL halt_hold[%0d]: op=%0d rdst=%0d rdsrc=%0d wb=%b m2r=%b cnt=%0d, want 5 2 3 1 0 0",
                 i, ex_alu_op, ex_reg_dst, mem_rd_src, wb_enable, wb_mem_to_reg, retired);
      end
      if (i < 5) tick();
    end
    drive(19'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (wb_enable !== 1'b0 || wb_mem_to_reg !== 1'b1 || mem_rd_src !== 3'd0 || ex_alu_op !== 3'd0
        || retired !== 4'd1) begin
      failures++;
      $display("FAIL halt_resume: wb=%b m2r=%b rdsrc=%0d op=%0d cnt=%0d, want 0 1 0 0 1",
               wb_enable, wb_mem_to_reg, mem_rd_src, ex_alu_op, retired);
    end
    tick();
    tick();
    checks++;
    if (retired !== 4'd3 || pipe_empty !== 1'b1) begin
      failures++;
      $display("FAIL halt_drain: cnt=%0d empty=%b, want 3 1", retired, pipe_empty);
    end
  endtask

  task automatic test_wrap_drain();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(mk(2'd1, 1'b0, 2'd0, 3'(i), 3'd0, 2'd0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(19'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (pipe_empty !== 1'b0) begin
      failures++;
      $display("FAIL drain_plus1: empty=%b, want 0", pipe_empty);
    end
    tick();
    checks++;
    if (pipe_empty !== 1'b0 || retired !== 4'd0) begin
      failures++;
      $display("FAIL drain_plus2: empty=%b cnt=%0d, want 0 0", pipe_empty, retired);
    end
    tick();
    checks++;
    if (pipe_empty !== 1'b1 || retired !== 4'd1) begin
      failures++;
      $display("FAIL wrap_plus3: empty=%b cnt=%0d, want 1 1", pipe_empty, retired);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(19'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_lw();
    test_stall();
    test_flush();
    test_halt();
    test_wrap_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
